// File: rtl/spi_stream_pkg.sv
// Shared types and constants for the SPI byte streamer.
//   st_e            : sequencer state encoding
//   *_DEF           : default IO / vector addresses and SPCR init value
//   SPE, MSTR       : SPCR bit positions used to build the init value
package spi_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      READY,
      LOAD,
      WAIT_IRQ,
      ACK,
      RD
   } st_e;

   localparam int SPE  = 6;
   localparam int MSTR = 4;

   localparam logic [5:0] SPCR_ADDR_DEF = 6'h2C;
   localparam logic [5:0] SPDR_ADDR_DEF = 6'h2E;
   localparam logic [5:0] IRQ_ADDR_DEF  = 6'h11;
   localparam logic [7:0] SPCR_INIT_DEF = 8'((1 << SPE) | (1 << MSTR));

endpackage

// File: rtl/spi_stream_fifo.sv
// Synchronous FIFO used for the TX and RX byte queues.
//   clk, rst        : clock, synchronous active-high flush
//   i_push, i_din   : write strobe and data (ignored while full)
//   i_pop           : read strobe (ignored while empty)
//   o_dout          : head entry, valid while !o_empty
//   o_full, o_empty : occupancy flags
module spi_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/spi_byte_streamer.sv
// Bus-master sequencer driving the SPI_0 IO register interface from a byte
// stream: configures SPCR on an en rise, then per byte writes SPDR, waits for
// SpiIRQ, acknowledges it and reads SPDR back into the RX stream.
//   cp2, ireset                : clock, synchronous active-high reset
//   en                         : level enable (rise triggers SPCR write)
//   tx_data/tx_valid/tx_ready  : input byte stream
//   rx_data/rx_valid/rx_ready  : received byte stream
//   io_addr/iowe/iore/io_wdata : SPI IO register bus, io_rdata read data
//   spi_irq/irqack/irqack_addr : SPI interrupt and acknowledge
//   busy, err, byte_count      : status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | disabled, waiting for an en rise
// CFG      | one-cycle SPCR write
// READY    | configured; starts a byte when TX has data and RX has room
// LOAD     | one-cycle SPDR write of the popped byte
// WAIT_IRQ | shift in progress, timeout counter running
// ACK      | two-cycle irqack pulse
// RD       | one-cycle SPDR read, result pushed to RX
module spi_byte_streamer
   import spi_stream_pkg::*;
#(
   parameter logic [5:0] SPCR_ADDR  = SPCR_ADDR_DEF,
   parameter logic [5:0] SPDR_ADDR  = SPDR_ADDR_DEF,
   parameter logic [5:0] IRQ_ADDR   = IRQ_ADDR_DEF,
   parameter logic [7:0] SPCR_INIT  = SPCR_INIT_DEF,
   parameter int         FIFO_DEPTH = 4,
   parameter int         TIMEOUT    = 1024
) (
   input  logic        cp2,
   input  logic        ireset,
   input  logic        en,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [5:0]  io_addr,
   output logic        iowe,
   output logic        iore,
   output logic [7:0]  io_wdata,
   input  logic [7:0]  io_rdata,
   input  logic        spi_irq,
   output logic        irqack,
   output logic [5:0]  irqack_addr,
   output logic        busy,
   output logic        err,
   output logic [15:0] byte_count
);

   localparam int             TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

   st_e            r_state;
   logic           r_en_q;
   logic [TW-1:0]  r_tmo;
   logic           r_ack_second;
   logic [7:0]     r_tx_byte;
   logic           r_err;
   logic [15:0]    r_byte_count;

   st_e            w_next;
   logic           w_tx_pop;
   logic           w_rx_push;
   logic [7:0]     w_tx_dout;
   logic           w_tx_full;
   logic           w_tx_empty;
   logic           w_rx_full;
   logic           w_rx_empty;
   logic           w_en_rise;
   logic           w_tmo_done;

   assign w_en_rise  = en & ~r_en_q;
   assign w_tmo_done = (r_tmo == TMO_LAST);

   // Held low while ireset is asserted so nothing is accepted into a FIFO
   // that is being flushed on the same edge.
   assign tx_ready   = ~w_tx_full & ~ireset;
   assign rx_valid   = ~w_rx_empty;
   assign busy       = (r_state != IDLE) && (r_state != READY);
   assign err        = r_err;
   assign byte_count = r_byte_count;

   spi_stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (cp2),
      .rst     (ireset),
      .i_push  (tx_valid & tx_ready),
      .i_din   (tx_data),
      .i_pop   (w_tx_pop),
      .o_dout  (w_tx_dout),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   spi_stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (cp2),
      .rst     (ireset),
      .i_push  (w_rx_push),
      .i_din   (io_rdata),
      .i_pop   (rx_valid & rx_ready),
      .o_dout  (rx_data),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   always_comb begin
      w_next      = r_state;
      w_tx_pop    = 1'b0;
      w_rx_push   = 1'b0;
      iowe        = 1'b0;
      iore        = 1'b0;
      irqack      = 1'b0;
      io_addr     = '0;
      io_wdata    = '0;
      irqack_addr = '0;
      case (r_state)
         IDLE: begin
            if (w_en_rise) w_next = CFG;
         end
         CFG: begin
            iowe     = 1'b1;
            io_addr  = SPCR_ADDR;
            io_wdata = SPCR_INIT;
            w_next   = READY;
         end
         READY: begin
            // Requiring an RX slot before starting means RD can never overrun.
            if (!en) begin
               w_next = IDLE;
            end else if (!w_tx_empty && !w_rx_full) begin
               w_tx_pop = 1'b1;
               w_next   = LOAD;
            end
         end
         LOAD: begin
            iowe     = 1'b1;
            io_addr  = SPDR_ADDR;
            io_wdata = r_tx_byte;
            w_next   = WAIT_IRQ;
         end
         WAIT_IRQ: begin
            if (spi_irq)         w_next = ACK;
            else if (w_tmo_done) w_next = IDLE;
         end
         ACK: begin
            irqack      = 1'b1;
            irqack_addr = IRQ_ADDR;
            if (r_ack_second) w_next = RD;
         end
         RD: begin
            iore      = 1'b1;
            io_addr   = SPDR_ADDR;
            w_rx_push = 1'b1;
            w_next    = READY;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge cp2) begin
      if (ireset) begin
         r_state      <= IDLE;
         r_en_q       <= 1'b0;
         r_tmo        <= '0;
         r_ack_second <= 1'b0;
         r_tx_byte    <= '0;
         r_err        <= 1'b0;
         r_byte_count <= '0;
      end else begin
         r_state      <= w_next;
         r_en_q       <= en;
         r_ack_second <= (r_state == ACK) && !r_ack_second;
         if (w_tx_pop) r_tx_byte <= w_tx_dout;
         if (r_state == LOAD)          r_tmo <= '0;
         else if (r_state == WAIT_IRQ) r_tmo <= r_tmo + TW'(1);
         if ((r_state == WAIT_IRQ) && !spi_irq && w_tmo_done) r_err <= 1'b1;
         if (w_rx_push) r_byte_count <= r_byte_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_spi_byte_streamer.sv
module tb_spi_byte_streamer;

   localparam int TMO = 1024;

   logic        cp2 = 1'b0;
   logic        ireset, en, tx_valid, rx_ready, spi_irq;
   logic [7:0]  tx_data, io_rdata;
   logic        tx_ready, rx_valid, iowe, iore, irqack, busy, err;
   logic [7:0]  rx_data, io_wdata;
   logic [5:0]  io_addr, irqack_addr;
   logic [15:0] byte_count;

   spi_byte_streamer #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
      .cp2(cp2), .ireset(ireset), .en(en),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .io_addr(io_addr), .iowe(iowe), .iore(iore),
      .io_wdata(io_wdata), .io_rdata(io_rdata),
      .spi_irq(spi_irq), .irqack(irqack), .irqack_addr(irqack_addr),
      .busy(busy), .err(err), .byte_count(byte_count)
   );

   always #5 cp2 = ~cp2;

   int cyc = 0;
   always @(posedge cp2) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard queues: expected SPDR write data, expected RX bytes, and the
   // bytes the attached slave shifts back for each transfer.
   logic [7:0] q_spdr_exp[$];
   logic [7:0] q_rx_exp[$];
   logic [7:0] q_slave[$];

   int cfg_cnt = 0, spdr_cnt = 0, rx_cnt = 0, t_load = 0, ack_len = 0;
   bit irq_en = 1'b1;

   // Bus monitor / scoreboard compare, sampled away from the active edge.
   initial begin
      forever begin
         @(negedge cp2);
         if (iowe && io_addr == 6'h2C) begin
            cfg_cnt++;
            check("cfg_wdata", 32'(io_wdata), 32'h50);
         end
         if (iowe && io_addr == 6'h2E) begin
            spdr_cnt++;
            t_load = cyc;
            check("spdr_expected", 32'(q_spdr_exp.size() != 0), 1);
            if (q_spdr_exp.size() != 0) check("spdr_wdata", 32'(io_wdata), 32'(q_spdr_exp.pop_front()));
         end
         if (iore) check("rd_addr", 32'(io_addr), 32'h2E);
         if (irqack) begin
            ack_len++;
            check("ack_addr", 32'(irqack_addr), 32'h11);
         end else if (ack_len != 0) begin
            check("ack_len", 32'(ack_len), 2);
            ack_len = 0;
         end
         if (rx_valid && rx_ready) begin
            rx_cnt++;
            check("rx_expected", 32'(q_rx_exp.size() != 0), 1);
            if (q_rx_exp.size() != 0) check("rx_data", 32'(rx_data), 32'(q_rx_exp.pop_front()));
         end
      end
   end

   // SPI_0 + slave model: SPDR write starts a shift of random length, after
   // which the slave's byte sits in SPDR and SpiIRQ rises until acknowledged.
   int         shift_cnt = 0;
   logic [7:0] slave_byte = '0;
   initial begin
      spi_irq  = 1'b0;
      io_rdata = '0;
      forever begin
         @(negedge cp2);
         if (ireset) begin
            shift_cnt = 0;
            spi_irq   = 1'b0;
         end else begin
            if (irqack) spi_irq = 1'b0;
            if (iowe && io_addr == 6'h2E) begin
               shift_cnt  = int'($urandom_range(6, 14));
               slave_byte = (q_slave.size() != 0) ? q_slave.pop_front() : 8'h00;
            end else if (shift_cnt > 0) begin
               shift_cnt--;
               if (shift_cnt == 0) begin
                  io_rdata = slave_byte;
                  if (irq_en) spi_irq = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge cp2);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] s, input bit exp_rx);
      bit ok;
      q_spdr_exp.push_back(b);
      q_slave.push_back(s);
      if (exp_rx) q_rx_exp.push_back(s);
      tx_data  = b;
      tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge cp2);
         ok = tx_ready;
         @(posedge cp2);
         #1;
      end
      tx_valid = 1'b0;
      check("tx_accept", 32'(ok), 1);
   endtask

   task automatic wait_bc(input logic [15:0] target, input string tag);
      for (int i = 0; i < 3000 && byte_count != target; i++) @(negedge cp2);
      check(tag, 32'(byte_count), 32'(target));
      tick(1);
   endtask

   task automatic wait_rx_drain(input string tag);
      for (int i = 0; i < 500 && q_rx_exp.size() != 0; i++) @(negedge cp2);
      tick(2);
      check(tag, 32'(q_rx_exp.size()), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_tx_ready"}, 32'(tx_ready), 1);
      check({tag, "_ctl"}, 32'({iowe, iore, irqack, busy, err, rx_valid}), 0);
      check({tag, "_addr"}, 32'({io_addr, irqack_addr}), 0);
      check({tag, "_wdata"}, 32'(io_wdata), 0);
      check({tag, "_count"}, 32'(byte_count), 0);
   endtask

   initial begin
      int  base_s, base_c, t_err, hi_cnt;
      bit  ok;
      logic [7:0] b;

      ireset = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
      tick(1);
      @(negedge cp2);
      check("rst_cycle_tx_ready", 32'(tx_ready), 0);
      @(posedge cp2); #1;
      ireset = 1'b0;
      @(negedge cp2);
      check_reset("rst");
      tick(1);

      // 1: config write then a three-byte burst
      rx_ready = 1'b1;
      en = 1'b1;
      tick(6);
      check("t1_cfg_once", 32'(cfg_cnt), 1);
      send(8'hA5, 8'h11, 1'b1);
      send(8'h3C, 8'h22, 1'b1);
      send(8'hF0, 8'h33, 1'b1);
      wait_bc(16'd3, "t1_byte_count");
      wait_rx_drain("t1_rx_drain");
      check("t1_spdr_writes", 32'(spdr_cnt), 3);
      check("t1_rx_count", 32'(rx_cnt), 3);
      check("t1_err", 32'(err), 0);

      // 2: RX back-pressure parks the FSM after FIFO_DEPTH bytes
      rx_ready = 1'b0;
      base_s = spdr_cnt;
      for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 8'($urandom_range(0, 255)), 1'b1);
      tick(200);
      check("t2_spdr_parked", 32'(spdr_cnt - base_s), 4);
      check("t2_busy_parked", 32'(busy), 0);
      check("t2_rx_valid", 32'(rx_valid), 1);
      rx_ready = 1'b1;
      wait_bc(16'd9, "t2_byte_count");
      wait_rx_drain("t2_rx_drain");
      check("t2_spdr_total", 32'(spdr_cnt - base_s), 6);

      // 3: no interrupt -> timeout; WAIT_IRQ lasts exactly TMO cycles
      irq_en = 1'b0;
      send(8'h55, 8'h99, 1'b0);
      ok = 1'b0;
      t_err = 0;
      for (int i = 0; i < TMO + 200 && !ok; i++) begin
         @(negedge cp2);
         if (err) begin ok = 1'b1; t_err = cyc; end
      end
      check("t3_err_set", 32'(err), 1);
      check("t3_err_delay", 32'(t_err - t_load), 32'(TMO + 1));
      check("t3_busy", 32'(busy), 0);
      check("t3_rx_valid", 32'(rx_valid), 0);
      check("t3_byte_count", 32'(byte_count), 9);
      irq_en = 1'b1;
      tick(1);

      // 4: reset during WAIT_IRQ (en stays high, so a new en rise follows)
      ireset = 1'b1;
      tick(1);
      ireset = 1'b0;
      tick(4);
      check("t4_err_cleared", 32'(err), 0);
      base_s = spdr_cnt;
      send(8'h6B, 8'hC4, 1'b1);
      for (int i = 0; i < 100 && spdr_cnt == base_s; i++) @(negedge cp2);
      tick(3);
      @(negedge cp2);
      check("t4_busy_wait", 32'(busy), 1);
      @(posedge cp2); #1;
      ireset = 1'b1;
      @(posedge cp2); #1;
      ireset = 1'b0;
      @(negedge cp2);
      check_reset("t4");
      q_rx_exp.delete();
      q_slave.delete();
      q_spdr_exp.delete();
      en = 1'b0;
      tick(4);

      // 5: fill TX while idle; the 5th byte waits for the first pop
      base_s = spdr_cnt;
      for (int i = 0; i < 4; i++) send(8'(8'hB0 + i), 8'(8'hD0 + i), 1'b1);
      @(negedge cp2);
      check("t5_full_tx_ready", 32'(tx_ready), 0);
      @(posedge cp2); #1;
      b = 8'hB4;
      q_spdr_exp.push_back(b); q_slave.push_back(8'hD4); q_rx_exp.push_back(8'hD4);
      tx_data = b; tx_valid = 1'b1;
      hi_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge cp2);
         if (tx_ready) hi_cnt++;
      end
      check("t5_held_off", 32'(hi_cnt), 0);
      @(posedge cp2); #1;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge cp2);
         ok = tx_ready;
         @(posedge cp2); #1;
      end
      tx_valid = 1'b0;
      check("t5_accept_5th", 32'(ok), 1);
      check("t5_after_first_pop", 32'(spdr_cnt - base_s), 1);
      wait_bc(16'd5, "t5_byte_count");
      wait_rx_drain("t5_rx_drain");
      check("t5_spdr_total", 32'(spdr_cnt - base_s), 5);

      // 6: drop en while byte 2 of 3 is shifting, then re-enable
      base_s = spdr_cnt;
      base_c = cfg_cnt;
      send(8'h71, 8'hE1, 1'b1);
      send(8'h72, 8'hE2, 1'b1);
      send(8'h73, 8'hE3, 1'b1);
      for (int i = 0; i < 200 && spdr_cnt < base_s + 2; i++) @(negedge cp2);
      @(posedge cp2); #1;
      en = 1'b0;
      tick(60);
      check("t6_byte_count", 32'(byte_count), 7);
      check("t6_spdr_two", 32'(spdr_cnt - base_s), 2);
      check("t6_idle", 32'(busy), 0);
      check("t6_tx_pending", 32'(q_spdr_exp.size()), 1);
      check("t6_rx_pending", 32'(q_rx_exp.size()), 1);
      en = 1'b1;
      wait_bc(16'd8, "t6_byte_count_final");
      wait_rx_drain("t6_rx_drain");
      check("t6_recfg", 32'(cfg_cnt - base_c), 1);
      check("t6_spdr_total", 32'(spdr_cnt - base_s), 3);
      check("t6_err", 32'(err), 0);

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
